// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, pixel types and the crosshair geometry helper
// used by the 320x240 double-buffered framebuffer scanout.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;
   localparam int CNT_W     = 10;

   typedef logic [11:0] rgb444_t;

   typedef struct packed {
      logic blank;
      logic hsync;
      logic vsync;
   } vga_flags_t;

   localparam vga_flags_t FLAGS_IDLE = '{blank: 1'b1, hsync: 1'b1, vsync: 1'b1};

   function automatic logic in_crosshair(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
      logic vbar;
      logic hbar;
      vbar = (h >= CNT_W'(319)) && (h <= CNT_W'(320)) && (v >= CNT_W'(230)) && (v <= CNT_W'(249));
      hbar = (v >= CNT_W'(239)) && (v <= CNT_W'(240)) && (h >= CNT_W'(310)) && (h <= CNT_W'(329));
      return vbar || hbar;
   endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read bus between the scanout (master) and the display BRAM bank (slave).
interface vga_scanout_if
   import vga_pkg::*;
#(
   parameter int ADDR_W = 17
);
   logic              rd_buffer_out;
   logic [ADDR_W-1:0] rd_addr_out;
   rgb444_t           rd_data_in;

   modport master (
      output rd_buffer_out,
      output rd_addr_out,
      input  rd_data_in
   );

   modport slave (
      input  rd_buffer_out,
      input  rd_addr_out,
      output rd_data_in
   );
endinterface

// File: rtl/vga_timing.sv
// 800x525 h/v counters with registered sync, blank, vblank and frame-start flags.
// Flags are computed from the next counter values so they line up with the counters.
module vga_timing
   import vga_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   output logic [CNT_W-1:0] o_hcount,
   output logic [CNT_W-1:0] o_vcount,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_blank,
   output logic             o_vblank,
   output logic             o_frame_start
);
   logic             r_run;
   logic [CNT_W-1:0] r_hcount;
   logic [CNT_W-1:0] r_vcount;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_blank;
   logic             r_vblank;
   logic             r_frame_start;
   logic [CNT_W-1:0] w_hcount_nxt;
   logic [CNT_W-1:0] w_vcount_nxt;

   // next counter values; the first cycle out of reset holds (0,0) so the frame starts there
   always_comb begin
      w_hcount_nxt = r_hcount;
      w_vcount_nxt = r_vcount;
      if (!r_run) begin
         w_hcount_nxt = CNT_W'(0);
         w_vcount_nxt = CNT_W'(0);
      end else if (r_hcount == CNT_W'(H_TOTAL - 1)) begin
         w_hcount_nxt = CNT_W'(0);
         if (r_vcount == CNT_W'(V_TOTAL - 1)) begin
            w_vcount_nxt = CNT_W'(0);
         end else begin
            w_vcount_nxt = r_vcount + CNT_W'(1);
         end
      end else begin
         w_hcount_nxt = r_hcount + CNT_W'(1);
         w_vcount_nxt = r_vcount;
      end
   end

   // counter and flag registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_run         <= 1'b0;
         r_hcount      <= CNT_W'(0);
         r_vcount      <= CNT_W'(0);
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_blank       <= 1'b1;
         r_vblank      <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_run         <= 1'b1;
         r_hcount      <= w_hcount_nxt;
         r_vcount      <= w_vcount_nxt;
         r_hsync       <= !((w_hcount_nxt >= CNT_W'(H_VISIBLE + H_FP)) &&
                            (w_hcount_nxt <  CNT_W'(H_VISIBLE + H_FP + H_SYNC)));
         r_vsync       <= !((w_vcount_nxt >= CNT_W'(V_VISIBLE + V_FP)) &&
                            (w_vcount_nxt <  CNT_W'(V_VISIBLE + V_FP + V_SYNC)));
         r_blank       <= !((w_hcount_nxt < CNT_W'(H_VISIBLE)) && (w_vcount_nxt < CNT_W'(V_VISIBLE)));
         r_vblank      <= (w_vcount_nxt >= CNT_W'(V_VISIBLE));
         r_frame_start <= (w_hcount_nxt == CNT_W'(0)) && (w_vcount_nxt == CNT_W'(0));
      end
   end

   assign o_hcount      = r_hcount;
   assign o_vcount      = r_vcount;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_blank       = r_blank;
   assign o_vblank      = r_vblank;
   assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_scanout.sv
// Read side of the double-buffered 320x240 framebuffer, shown 2x2 on 640x480@60 VGA.
// Optional overlay: define CROSSHAIR_EN to enable the centre crosshair driven by crosshair_in.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int ADDR_W       = 17
)(
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          buffer_sel_in,
   input  logic          crosshair_in,
   vga_scanout_if.master rd_bus,
   output logic          frame_start_out,
   output logic          vblank_out,
   output logic          hsync_out,
   output logic          vsync_out,
   output rgb444_t       rgb_out
);
   // flags wait through the address register and the BRAM; the output register adds the last cycle
   localparam int PIPE_D = READ_LATENCY + 1;

   logic [CNT_W-1:0]  w_hcount;
   logic [CNT_W-1:0]  w_vcount;
   logic              w_hsync;
   logic              w_vsync;
   logic              w_blank;
   logic [ADDR_W-1:0] w_fb_x;
   logic [ADDR_W-1:0] w_fb_y;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_xhair;
   logic [ADDR_W-1:0] r_addr;
   logic              r_buf;
   vga_flags_t        r_flag_pipe [PIPE_D];

   vga_timing u_timing (
      .i_clk         (clk_in),
      .i_rst         (rst_in),
      .o_hcount      (w_hcount),
      .o_vcount      (w_vcount),
      .o_hsync       (w_hsync),
      .o_vsync       (w_vsync),
      .o_blank       (w_blank),
      .o_vblank      (vblank_out),
      .o_frame_start (frame_start_out)
   );

   // buffer index y*320 + x built from shifts: 320 = 256 + 64
   always_comb begin
      w_fb_y     = ADDR_W'(w_vcount >> 1);
      w_fb_x     = ADDR_W'(w_hcount >> 1);
      w_addr_nxt = (w_fb_y << 4'd8) + (w_fb_y << 4'd6) + w_fb_x;
   end

   // address register and frame-boundary bank latch
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_addr <= ADDR_W'(0);
         r_buf  <= 1'b0;
      end else begin
         if (!w_blank) begin
            r_addr <= w_addr_nxt;
         end
         if ((w_hcount == CNT_W'(H_TOTAL - 1)) && (w_vcount == CNT_W'(V_TOTAL - 1))) begin
            r_buf <= buffer_sel_in;
         end
      end
   end

   assign rd_bus.rd_addr_out   = r_addr;
   assign rd_bus.rd_buffer_out = r_buf;

   // sync/blank delay line matching the address + BRAM path
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < PIPE_D; i++) begin
            r_flag_pipe[i] <= FLAGS_IDLE;
         end
      end else begin
         r_flag_pipe[0] <= '{blank: w_blank, hsync: w_hsync, vsync: w_vsync};
         for (int i = 1; i < PIPE_D; i++) begin
            r_flag_pipe[i] <= r_flag_pipe[i-1];
         end
      end
   end

`ifdef CROSSHAIR_EN
   logic [CNT_W-1:0] r_h_pipe [PIPE_D];
   logic [CNT_W-1:0] r_v_pipe [PIPE_D];

   // coordinate delay line so the overlay lands on the pixel being output
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < PIPE_D; i++) begin
            r_h_pipe[i] <= CNT_W'(0);
            r_v_pipe[i] <= CNT_W'(0);
         end
      end else begin
         r_h_pipe[0] <= w_hcount;
         r_v_pipe[0] <= w_vcount;
         for (int i = 1; i < PIPE_D; i++) begin
            r_h_pipe[i] <= r_h_pipe[i-1];
            r_v_pipe[i] <= r_v_pipe[i-1];
         end
      end
   end

   // overlay hit for the delayed pixel
   always_comb begin
      if (crosshair_in) begin
         w_xhair = in_crosshair(r_h_pipe[PIPE_D-1], r_v_pipe[PIPE_D-1]);
      end else begin
         w_xhair = 1'b0;
      end
   end
`else
   logic w_unused_crosshair;
   assign w_unused_crosshair = crosshair_in;
   assign w_xhair            = 1'b0;
`endif

   // pin output register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
         rgb_out   <= 12'h000;
      end else begin
         hsync_out <= r_flag_pipe[PIPE_D-1].hsync;
         vsync_out <= r_flag_pipe[PIPE_D-1].vsync;
         if (r_flag_pipe[PIPE_D-1].blank) begin
            rgb_out <= 12'h000;
         end else if (w_xhair) begin
            rgb_out <= 12'hFFF;
         end else begin
            rgb_out <= rd_bus.rd_data_in;
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized bench for vga_scanout: a cycle-index reference model derives counters, address,
// sync and pixel values from the timing rules and is compared every cycle.
module tb_vga_scanout;
   import vga_pkg::*;

   logic    clk_in = 1'b0;
   logic    rst_in;
   logic    buffer_sel_in;
   logic    crosshair_in;
   logic    frame_start_out;
   logic    vblank_out;
   logic    hsync_out;
   logic    vsync_out;
   rgb444_t rgb_out;

   vga_scanout_if #(.ADDR_W(17)) bus ();

   vga_scanout #(.READ_LATENCY(2), .ADDR_W(17)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .buffer_sel_in   (buffer_sel_in),
      .crosshair_in    (crosshair_in),
      .rd_bus          (bus),
      .frame_start_out (frame_start_out),
      .vblank_out      (vblank_out),
      .hsync_out       (hsync_out),
      .vsync_out       (vsync_out),
      .rgb_out         (rgb_out)
   );

   always #5 clk_in = ~clk_in;

   // BRAM model: two-cycle read latency, data = low 12 address bits
   logic [11:0] bram_q1;
   logic [11:0] bram_q2;
   always @(posedge clk_in) begin
      bram_q1 <= bus.rd_addr_out[11:0];
      bram_q2 <= bram_q1;
   end
   assign bus.rd_data_in = bram_q2;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n       = -1;
   int   m_addr  = 0;
   logic m_buf   = 1'b0;
   logic m_xh    = 1'b0;
   logic prev_hs = 1'b1;
   int   hs_run  = 0;

   task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at n=%0d: got %0h, expected %0h", tag, n, got, exp);
      end
   endtask

   function automatic int pos_h(input int k);
      return k % 800;
   endfunction

   function automatic int pos_v(input int k);
      return (k / 800) % 525;
   endfunction

   function automatic bit visible(input int h, input int v);
      return (h < 640) && (v < 480);
   endfunction

   function automatic int fb_addr(input int h, input int v);
      return (v / 2) * 320 + (h / 2);
   endfunction

   function automatic bit xhair_hit(input int h, input int v);
      return ((h == 319 || h == 320) && v >= 230 && v <= 249) ||
             ((v == 239 || v == 240) && h >= 310 && h <= 329);
   endfunction

   // model update for one rising edge, using the inputs as sampled at that edge
   task automatic model_edge();
      int h;
      int v;
      if (rst_in) begin
         n      = -1;
         m_addr = 0;
         m_buf  = 1'b0;
      end else begin
         if (n >= 0) begin
            h = pos_h(n);
            v = pos_v(n);
            if (visible(h, v)) m_addr = fb_addr(h, v);
            if (h == 799 && v == 524) m_buf = buffer_sel_in;
         end
         n++;
      end
      m_xh = crosshair_in;
   endtask

   task automatic compare();
      int   h;
      int   v;
      int   ph;
      int   pv;
      logic e_hs;
      logic e_vs;
      int   e_rgb;
      if (n < 0) begin
         chk_value("rst_fs",   frame_start_out, 0);
         chk_value("rst_vb",   vblank_out, 0);
         chk_value("rst_hs",   hsync_out, 1);
         chk_value("rst_vs",   vsync_out, 1);
         chk_value("rst_rgb",  rgb_out, 0);
         chk_value("rst_addr", bus.rd_addr_out, 0);
         chk_value("rst_buf",  bus.rd_buffer_out, 0);
      end else begin
         h = pos_h(n);
         v = pos_v(n);
         chk_value("frame_start", frame_start_out, (h == 0 && v == 0) ? 1 : 0);
         chk_value("vblank", vblank_out, (v >= 480) ? 1 : 0);
         chk_value("rd_addr", bus.rd_addr_out, m_addr);
         chk_value("rd_buffer", bus.rd_buffer_out, m_buf);
         if (n < 4) begin
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_rgb = 0;
         end else begin
            ph    = pos_h(n - 4);
            pv    = pos_v(n - 4);
            e_hs  = !(ph >= 656 && ph <= 751);
            e_vs  = !(pv >= 490 && pv <= 491);
            e_rgb = 0;
            if (visible(ph, pv)) begin
               e_rgb = fb_addr(ph, pv) % 4096;
`ifdef CROSSHAIR_EN
               if (m_xh && xhair_hit(ph, pv)) e_rgb = 12'hFFF;
`endif
            end
         end
         chk_value("hsync", hsync_out, e_hs);
         chk_value("vsync", vsync_out, e_vs);
         chk_value("rgb", rgb_out, e_rgb);
         if (n == 4004) chk_value("addr_h3_v5", bus.rd_addr_out, 641);
         if (n == 4007) chk_value("rgb_h3_v5", rgb_out, 641);
      end
      // hsync pulse shape measured directly on the pin
      if (n < 4) begin
         prev_hs = 1'b1;
         hs_run  = 0;
      end else begin
         if (prev_hs && !hsync_out) chk_value("hs_fall_pos", n % 800, 660);
         if (!prev_hs && hsync_out) chk_value("hs_width", hs_run, 96);
         if (!hsync_out) hs_run++;
         else hs_run = 0;
         prev_hs = hsync_out;
      end
   endtask

   task automatic run_cycle();
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
      compare();
      if ($urandom_range(0, 99) == 0) buffer_sel_in = ~buffer_sel_in;
      if ($urandom_range(0, 199) == 0) crosshair_in = ~crosshair_in;
   endtask

   task automatic segment(input int rst_cycles, input int run_cycles);
      rst_in = 1'b1;
      for (int i = 0; i < rst_cycles; i++) run_cycle();
      rst_in = 1'b0;
      for (int i = 0; i < run_cycles; i++) run_cycle();
   endtask

   initial begin
      rst_in        = 1'b1;
      buffer_sel_in = 1'b0;
      crosshair_in  = 1'b0;
      segment(3, 6 * 800 + 20);
      for (int s = 0; s < 4; s++) begin
         segment(int'($urandom_range(1, 3)), int'($urandom_range(900, 9000)));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
